// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: two requester ports plus the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  req0, lock0, we0, gnt0, rvalid0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0, rdata0;
    logic                  req1, lock1, we1, gnt1, rvalid1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1, rdata1;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data, mem_in;

    modport slave (
        input  req0, lock0, we0, addr0, wdata0, req1, lock1, we1, addr1, wdata1, mem_in,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_we, mem_addr, mem_data
    );

    modport master (
        output req0, lock0, we0, addr0, wdata0, req1, lock1, we1, addr1, wdata1, mem_in,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between two requesters, with bounded lock
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOCK   = 4
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

    localparam logic [3:0] LAST_LOCK = 4'(MAX_LOCK - 1);

    state_t     state_q, state_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       last_q, last_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;
    logic       win0, win1;

    // An owner excludes the other port; in ARB a lone requester wins, contention goes to the port that is not last
    assign win0 = (state_q == OWN0) ? bus.req0 : (state_q == ARB) & bus.req0 & (~bus.req1 | last_q);
    assign win1 = (state_q == OWN1) ? bus.req1 : (state_q == ARB) & bus.req1 & (~bus.req0 | ~last_q);

    // State register; reset drops ownership and any read in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
            last_q     <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Next state: lock entry, lock extension up to the bound, release on unlock/idle/bound
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_d     = win1 ? 1'b1 : win0 ? 1'b0 : last_q;
        rd_pend_d  = (win0 | win1) & ~bus.mem_we;
        rd_owner_d = win1;
        case (state_q)
            ARB: begin
                state_d    = (win0 & bus.lock0) ? OWN0 : (win1 & bus.lock1) ? OWN1 : ARB;
                lock_cnt_d = (state_d == ARB) ? 4'd0 : 4'd1;
            end
            OWN0: begin
                state_d    = (win0 & bus.lock0 & (lock_cnt_q < LAST_LOCK)) ? OWN0 : ARB;
                lock_cnt_d = (state_d == OWN0) ? lock_cnt_q + 4'd1 : 4'd0;
            end
            OWN1: begin
                state_d    = (win1 & bus.lock1 & (lock_cnt_q < LAST_LOCK)) ? OWN1 : ARB;
                lock_cnt_d = (state_d == OWN1) ? lock_cnt_q + 4'd1 : 4'd0;
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = 4'd0;
            end
        endcase
    end

    // Outputs: winner's command onto the memory bus, read data shared and qualified by rvalid
    always_comb begin
        bus.gnt0     = win0;
        bus.gnt1     = win1;
        bus.mem_we   = win0 ? bus.we0 : win1 ? bus.we1 : 1'b0;
        bus.mem_addr = win0 ? bus.addr0 : win1 ? bus.addr1 : '0;
        bus.mem_data = win0 ? bus.wdata0 : win1 ? bus.wdata1 : '0;
        bus.rvalid0  = rd_pend_q & ~rd_owner_q;
        bus.rvalid1  = rd_pend_q & rd_owner_q;
        bus.rdata0   = bus.mem_in;
        bus.rdata1   = bus.mem_in;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data/program memory port between two requesters: port 0 (CPU core) and port 1 (program loader / debug master).
- Sits between the requesters and the memory, and drives the memory's we/addr/data signals.
- Read timing: address is issued in cycle N and read data returns in cycle N+1.
- Arbitration is round-robin. A lock lets one requester keep the port for back-to-back accesses (e.g. a 2-word instruction fetch), with a bounded lock length.

Parameters:
- ADDR_WIDTH, 6, memory address width
- DATA_WIDTH, 16, memory word width
- MAX_LOCK, 4, maximum consecutive locked grants to one owner (range 2..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0  in  1  port 0 access request; held until gnt0
- lock0  in  1  port 0 wants to keep ownership after this grant
- we0  in  1  port 0 write enable (1 = write, 0 = read)
- addr0  in  ADDR_WIDTH  port 0 address
- wdata0  in  DATA_WIDTH  port 0 write data
- gnt0  out  1  port 0 access issued this cycle
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DATA_WIDTH  port 0 read data
- req1, lock1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data  out  DATA_WIDTH  memory write data
- mem_in  in  DATA_WIDTH  memory read data (valid the cycle after the address)

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - state = ARB, last = 1 (so port 0 wins the first contention), lock_cnt = 0
  - rd_pend = 0, rd_owner = 0, so rvalid0 = rvalid1 = 0
  - gnt0/1 and mem_* are combinational; with no requests they are 0.
- States: ARB, OWN0, OWN1.
- Winner selection (combinational, same cycle as the request):
  - ARB: a single requester wins. If both request, the winner is the port that is not `last`.
  - OWNx: only port x can win. The other port's request is held and gets no grant.
  - No winner: gnt0 = gnt1 = 0 and mem_we/mem_addr/mem_data = 0.
- Grant cycle:
  - gntW = 1.
  - mem_we/mem_addr/mem_data = weW/addrW/wdataW of the winner W.
  - Exactly one grant per cycle; gnt0 and gnt1 are never both 1.
  - Zero-latency grant: a request in ARB with no contention is granted in the same cycle.
- Each grant updates `last` to the winner.
- Read return:
  - A granted read sets rd_pend = 1 and rd_owner = W at the clock edge.
  - Next cycle: rvalid_owner = 1; rdata0 = rdata1 = mem_in at all times, and rvalid qualifies it.
  - Writes produce no rvalid.
- Back-to-back reads: reads granted in consecutive cycles produce rvalid in consecutive cycles. Pipelined, no bubble.
- Transitions:
  - ARB → OWNx: port x granted with lockx = 1; lock_cnt = 1.
  - OWNx, granted with lockx = 1 and lock_cnt < MAX_LOCK−1: stay in OWNx, lock_cnt += 1.
  - OWNx, granted with lockx = 0, or lock_cnt = MAX_LOCK−1 (forced release on the MAX_LOCK-th locked grant): go to ARB, lock_cnt = 0.
  - OWNx with reqx = 0: go to ARB, lock_cnt = 0, no grant this cycle.
  - Lock is a request for ownership only: a lock with no req is ignored.
- Fairness: after a release, the other port wins the next contention because `last` was updated.
  - Bound on wait: a waiting requester is granted within MAX_LOCK+1 cycles.
- Simultaneous events: a read return for one port and a new grant to the other port in the same cycle are both legal and independent.
- Reset mid-operation: a pending read is dropped (no rvalid after reset), ownership is lost, and the block returns to ARB.

Test Plan:
- Single read, port 0: req0 = 1, we0 = 0, addr0 = 6'd8, memory holds 16'h1234 at 8 → same cycle gnt0 = 1, mem_addr = 8, mem_we = 0; next cycle rvalid0 = 1, rdata0 = 16'h1234, rvalid1 = 0.
- Contention after reset: req0 = req1 = 1 (reads of 3 and 5), held → cycle 1 gnt0 = 1 (mem_addr = 3); cycle 2 gnt1 = 1 (mem_addr = 5); rvalid0 in cycle 2, rvalid1 in cycle 3.
- Locked 2-word fetch: port 0 reads 8 then 9 with lock0 = 1 on the first and lock0 = 0 on the second, while req1 = 1 continuously → gnt0, gnt0, then gnt1; state returns to ARB.
- Lock bound: lock0 = req0 = 1 held forever with req1 = 1, MAX_LOCK = 4 → exactly 4 consecutive gnt0, then gnt1 in cycle 5.
- Write: req1 = 1, we1 = 1, addr1 = 2, wdata1 = 16'h00FF → mem_we = 1, mem_addr = 2, mem_data = 16'h00FF for one cycle; no rvalid1; a port 0 read of 2 afterwards returns 16'h00FF.
- Reset mid-read: grant a read, assert rst before the next clock edge → rvalid0/1 stay 0 and state = ARB; after release, req1 alone is granted immediately.
